// File: rtl/mode_sequencer.sv
// mode_sequencer: steps the graphics engine through a fixed scene table, shows a one-bit flash between scenes, and passes manual_modes through in manual mode.
module mode_sequencer #(
  parameter int FRAMES_PER_SCENE = 120,
  parameter int FLASH_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       auto_en,
  input  logic [6:0] manual_modes,
  input  logic       next_btn,
  output logic [6:0] video_modes,
  output logic [2:0] scene_idx,
  output logic       frame_tick
);
  typedef enum logic [1:0] {MANUAL, RUN, FLASH} state_t;
  localparam logic [55:0] SCENES = {7'b0000110, 7'b0001100, 7'b0000001, 7'b1000000,
                                    7'b0001000, 7'b0000010, 7'b0000100, 7'b0000000};
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SCENE - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_FRAMES - 1);
  if (FRAMES_PER_SCENE < 2 || FRAMES_PER_SCENE > 255) begin : g_bad_frames
    $error("FRAMES_PER_SCENE must be 2..255 to fit the 8-bit frame counter");
  end
  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15) begin : g_bad_flash
    $error("FLASH_FRAMES must be 1..15 to fit the 4-bit flash counter");
  end
  state_t state, state_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [3:0] flash_cnt, flash_cnt_n;
  logic [2:0] scene_n;
  logic [6:0] scene_modes;
  logic vs_d, btn_s1, btn_s2, btn_s3;
  logic next_req, frame_end, flash_end;
  assign next_req = btn_s2 & ~btn_s3;
  assign frame_end = frame_tick && frame_cnt == FRAME_LAST;
  assign flash_end = frame_tick && flash_cnt == FLASH_LAST;
  assign scene_modes = SCENES[7*scene_idx +: 7];
  // Dropping auto_en wins over every tick or button request in the same cycle.
  always_comb begin
    state_n = state;
    frame_cnt_n = frame_cnt;
    flash_cnt_n = flash_cnt;
    scene_n = scene_idx;
    if (state != MANUAL && !auto_en) begin
      state_n = MANUAL;
      frame_cnt_n = '0;
      flash_cnt_n = '0;
    end else if (state == MANUAL) begin
      if (auto_en) begin
        state_n = RUN;
        frame_cnt_n = '0;
      end
    end else if (state == RUN) begin
      if (next_req || frame_end) begin
        state_n = FLASH;
        frame_cnt_n = '0;
        flash_cnt_n = '0;
      end else if (frame_tick) frame_cnt_n = frame_cnt + 8'd1;
    end else if (flash_end) begin
      state_n = RUN;
      scene_n = scene_idx + 3'd1;
      frame_cnt_n = '0;
      flash_cnt_n = '0;
    end else if (frame_tick) flash_cnt_n = flash_cnt + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
      frame_cnt <= '0;
      flash_cnt <= '0;
      scene_idx <= '0;
      video_modes <= '0;
      frame_tick <= 1'b0;
      vs_d <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      state <= state_n;
      frame_cnt <= frame_cnt_n;
      flash_cnt <= flash_cnt_n;
      scene_idx <= scene_n;
      video_modes <= state == MANUAL ? manual_modes : state == RUN ? scene_modes : scene_modes ^ 7'b0000001;
      frame_tick <= v_sync & ~vs_d;
      vs_d <= v_sync;
      btn_s1 <= next_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end
endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter FRAMES_PER_SCENE, default 120; frames a scene is shown before its transition flash; range 2..255.
REQ-002 Parameter FLASH_FRAMES, default 2; frames in the transition flash; range 1..15.
REQ-003 Port clk  input  1  system/pixel clock; the only clock.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port v_sync  input  1  vertical sync from the timing generator, synchronous to clk, active-high.
REQ-006 Port auto_en  input  1  1 = automatic scene sequencing, 0 = manual; synchronous to clk.
REQ-007 Port manual_modes  input  7  mode word passed through in manual mode.
REQ-008 Port next_btn  input  1  pushbutton, asynchronous to clk, active-high; requests an early scene advance.
REQ-009 Port video_modes  output  7  registered mode word to the graphics engine: bit6 freeze animation, bit5 day/night, bit4 text style, bit3 overlay off, bit2 big sine off, bit1 little sine off, bit0 negative.
REQ-010 Port scene_idx  output  3  registered index of the current scene.
REQ-011 Port frame_tick  output  1  registered one-cycle pulse per v_sync rising edge.

Function
REQ-012 frame_tick SHALL pulse high for exactly one cycle, one cycle after the first clk edge that samples v_sync=1 following a sample of v_sync=0.
REQ-013 next_btn SHALL pass through a 2-flop synchronizer; the rising edge of the synchronized signal SHALL form a one-cycle next_req pulse.
REQ-014 Scene table, fixed: 0=0000000, 1=0000100, 2=0000010, 3=0001000, 4=1000000, 5=0000001, 6=0001100, 7=0000110.
REQ-015 States: MANUAL, RUN, FLASH. frame_cnt is 8 bits; flash_cnt is 4 bits.
REQ-016 MANUAL: video_modes <= manual_modes every cycle. auto_en=1 -> RUN with frame_cnt=0. scene_idx SHALL be held.
REQ-017 RUN: video_modes <= table[scene_idx]. Each frame_tick increments frame_cnt.
REQ-018 RUN: a frame_tick with frame_cnt=FRAMES_PER_SCENE-1 -> FLASH with frame_cnt=0 and flash_cnt=0.
REQ-019 RUN: next_req -> FLASH immediately with frame_cnt=0 and flash_cnt=0. next_req coinciding with the terminal frame_tick SHALL cause a single FLASH entry.
REQ-020 FLASH: video_modes <= table[scene_idx] XOR 0000001. Each frame_tick increments flash_cnt.
REQ-021 FLASH: a frame_tick with flash_cnt=FLASH_FRAMES-1 -> RUN, scene_idx <= scene_idx+1 (mod 8, 7 wraps to 0), frame_cnt=0.
REQ-022 FLASH: next_req SHALL be ignored and SHALL not be queued.
REQ-023 auto_en=0 in RUN or FLASH -> MANUAL on the next clock, with frame_cnt=0 and flash_cnt=0. This SHALL take priority over frame_tick and next_req in the same cycle. scene_idx SHALL be retained and SHALL not advance.
REQ-024 next_req in MANUAL SHALL be ignored.
REQ-025 video_modes SHALL update one cycle after the state or scene_idx change that selects its new value.
REQ-026 Counters SHALL never exceed their terminal values; the counter width SHALL be checked against the parameters at elaboration.

Reset
REQ-027 On rst_n=0 the block SHALL immediately enter MANUAL with video_modes=0000000, scene_idx=0, frame_tick=0, frame_cnt=0, flash_cnt=0, synchronizer flops=0, v_sync history=0.
REQ-028 Reset asserted mid-FLASH SHALL abandon the flash; after release with auto_en=1, the block SHALL enter RUN at scene 0.
REQ-029 After rst_n deasserts, the first active edge SHALL behave as a normal clock edge; a v_sync already high at release SHALL produce one frame_tick.

Verification (bench: FRAMES_PER_SCENE=4, FLASH_FRAMES=2)
REQ-030 Reset, auto_en=0, manual_modes=1010101 -> one cycle later video_modes=1010101 and scene_idx=0; 20 v_sync pulses -> scene_idx stays 0.
REQ-031 auto_en=1, 4 v_sync pulses -> video_modes=0000000, then 0000001 for 2 frames, then 0000100 with scene_idx=1.
REQ-032 Run 8 full scenes -> scene_idx sequence 0..7 then 0; in scene 5 the flash word is 0000000.
REQ-033 In RUN scene 2 after 1 frame, pulse next_btn for 3 cycles -> FLASH within 4 cycles (video_modes=0000011). A second press during FLASH has no effect: after 2 frames scene_idx=3.
REQ-034 Deassert auto_en mid-FLASH in scene 3 -> next cycle MANUAL; video_modes=manual_modes one cycle later; scene_idx=3. Reassert -> RUN scene 3 with the full 4-frame dwell.
REQ-035 Assert rst_n=0 during FLASH asynchronously (between clk edges) -> video_modes=0000000 and scene_idx=0 with no clock edge; release with auto_en=1 -> RUN, video_modes=0000000.
